// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: op-code encoding from the ALU control unit,
// FSM state encoding and default widths.
package alu_pkg;

  localparam int unsigned DataWidthDef  = 32;
  localparam int unsigned ShamtWidthDef = 5;

  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpOr  = 4'b0001;
  localparam logic [3:0] OpNor = 4'b0010;
  localparam logic [3:0] OpAdd = 4'b0011;
  localparam logic [3:0] OpSub = 4'b0100;
  localparam logic [3:0] OpSll = 4'b1000;
  localparam logic [3:0] OpSrl = 4'b1001;
  localparam logic [3:0] OpBeq = 4'b1100;

  // StDone is never entered: completion is signalled in the last EXEC/SHIFT cycle.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StExec  = 2'd1,
    StShift = 2'd2,
    StDone  = 2'd3
  } alu_state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OpSll) || (op == OpSrl);
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Combinational logic/arithmetic unit and op-code legality decode.
// Shift ops are legal here but produce no result; the top iterates them.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DataWidthDef
) (
  input  logic [3:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  illegal_o
);

  always_comb begin
    result_o  = '0;
    illegal_o = 1'b0;
    case (op_i)
      OpAnd:        result_o = a_i & b_i;
      OpOr:         result_o = a_i | b_i;
      OpNor:        result_o = ~(a_i | b_i);
      OpAdd:        result_o = a_i + b_i;
      OpSub, OpBeq: result_o = a_i - b_i;
      OpSll, OpSrl: result_o = '0;
      default:      illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_alu.sv
// Execute-stage ALU with start/done handshake: logic/arithmetic ops finish in one cycle,
// shifts iterate one bit per cycle through a working register.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DataWidthDef,
  parameter int unsigned SHAMT_WIDTH = ShamtWidthDef
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             ALUOperation,
  input  logic [DATA_WIDTH-1:0]  A,
  input  logic [DATA_WIDTH-1:0]  B,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  output logic                   busy,
  output logic                   done,
  output logic [DATA_WIDTH-1:0]  ALUResult,
  output logic                   Zero,
  output logic                   illegal
);

  alu_state_e             state_q, state_d;
  logic [3:0]             op_q, op_d;
  logic [DATA_WIDTH-1:0]  a_q, a_d;
  logic [DATA_WIDTH-1:0]  b_q, b_d;  // doubles as the shift working register
  logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  res_q, res_d;
  logic                   zero_q, zero_d;
  logic                   ill_q, ill_d;
  logic                   fin;

  logic [DATA_WIDTH-1:0]  core_res;
  logic                   core_ill;

  alu_comb_core #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_core (
    .op_i     (op_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .result_o (core_res),
    .illegal_o(core_ill)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    ill_d   = ill_q;
    fin     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d    = ALUOperation;
          a_d     = A;
          b_d     = B;
          cnt_d   = shamt;
          state_d = is_shift(ALUOperation) ? StShift : StExec;
        end
      end
      StExec: begin
        fin     = 1'b1;
        res_d   = core_res;
        ill_d   = core_ill;
        state_d = StIdle;
      end
      StShift: begin
        if (cnt_q != '0) begin
          b_d   = (op_q == OpSll) ? (b_q << 1) : (b_q >> 1);
          cnt_d = cnt_q - 1'b1;
        end else begin
          fin     = 1'b1;
          res_d   = b_q;
          ill_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    zero_d = fin ? (res_d == '0) : zero_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b1;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
    end
  end

  // The finishing result is forwarded so it is visible during the done cycle itself.
  always_comb begin
    busy      = (state_q != StIdle);
    done      = fin & ~reset;
    ALUResult = done ? res_d  : res_q;
    Zero      = done ? zero_d : zero_q;
    illegal   = done ? ill_d  : ill_q;
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Randomized self-checking bench for multicycle_alu against a behavioural op model.
module tb_multicycle_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  ALUOperation;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        illegal;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multicycle_alu #(
    .DATA_WIDTH (32),
    .SHAMT_WIDTH(5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ALUOperation(ALUOperation),
    .A           (A),
    .B           (B),
    .shamt       (shamt),
    .busy        (busy),
    .done        (done),
    .ALUResult   (ALUResult),
    .Zero        (Zero),
    .illegal     (illegal)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] sh, output logic [31:0] r, output logic ill,
                                output int lat);
    ill = 1'b0;
    lat = 1;
    case (op)
      4'd0:        r = a & b;
      4'd1:        r = a | b;
      4'd2:        r = ~(a | b);
      4'd3:        r = a + b;
      4'd4, 4'd12: r = a - b;
      4'd8:        begin r = b << sh; lat = 1 + int'(sh); end
      4'd9:        begin r = b >> sh; lat = 1 + int'(sh); end
      default:     begin r = 32'd0; ill = 1'b1; end
    endcase
  endfunction

  // Called just after a negedge; returns just after the negedge of the idle cycle following done,
  // so back-to-back calls issue a new op in the cycle after done.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input bit poke);
    logic [31:0] er;
    logic        eill;
    int          elat;
    int          n;
    bit          seen;
    model(op, a, b, sh, er, eill, elat);
    start = 1'b1; ALUOperation = op; A = a; B = b; shamt = sh;
    @(posedge clk); #1;
    start = 1'b0;
    ALUOperation = 4'($urandom); A = $urandom; B = $urandom; shamt = 5'($urandom);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
      else begin
        check_eq("busy_wait", {31'd0, busy}, 32'd1);
        if (poke) start = 1'($urandom);
      end
    end
    start = 1'b0;
    check_eq("done_seen", {31'd0, seen}, 32'd1);
    if (seen) begin
      check_eq("latency", n, elat);
      check_eq("result", ALUResult, er);
      check_eq("zero", {31'd0, Zero}, {31'd0, er == 32'd0});
      check_eq("illegal", {31'd0, illegal}, {31'd0, eill});
      check_eq("busy_at_done", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    check_eq("done_pulse", {31'd0, done}, 32'd0);
    check_eq("busy_idle", {31'd0, busy}, 32'd0);
    check_eq("result_held", ALUResult, er);
    check_eq("zero_held", {31'd0, Zero}, {31'd0, er == 32'd0});
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_result"}, ALUResult, 32'd0);
    check_eq({tag, "_zero"}, {31'd0, Zero}, 32'd1);
    check_eq({tag, "_illegal"}, {31'd0, illegal}, 32'd0);
  endtask

  logic [3:0] op_tab [11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9, 4'd12, 4'd5, 4'd15, 4'd10};

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    reset = 1'b1; start = 1'b0; ALUOperation = '0; A = '0; B = '0; shamt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("rst");
    reset = 1'b0;
    @(negedge clk);

    // Non-zero result first so the reset clearing below is observable.
    run_op(4'd3, 32'h0000_0010, 32'h0000_0022, 5'd0, 1'b0);

    // Reset in the middle of a 20-cycle shift.
    start = 1'b1; ALUOperation = 4'd8; A = '0; B = 32'h3; shamt = 5'd20;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check_eq("pre_rst_done", {31'd0, done}, 32'd0);
    end
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_eq("in_rst_done", {31'd0, done}, 32'd0);
    end
    reset = 1'b0;
    check_reset_state("midrst");
    repeat (25) begin
      @(negedge clk);
      check_eq("post_rst_done", {31'd0, done}, 32'd0);
    end

    run_op(4'd3, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 1'b0);
    run_op(4'd8, 32'h0, 32'h0000_0003, 5'd4, 1'b1);
    run_op(4'd9, 32'h0, 32'h8000_0000, 5'd31, 1'b1);
    run_op(4'd9, 32'h0, 32'h0000_1234, 5'd0, 1'b0);
    run_op(4'd12, 32'h0000_ABCD, 32'h0000_ABCD, 5'd0, 1'b0);
    run_op(4'd4, 32'd5, 32'd7, 5'd0, 1'b0);
    run_op(4'd15, 32'd3, 32'd3, 5'd0, 1'b0);
    run_op(4'd2, 32'd0, 32'd0, 5'd0, 1'b0);

    repeat (150) begin
      rop = op_tab[$urandom_range(0, 10)];
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      run_op(rop, ra, rb, 5'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
